// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared funct codes, state/op encodings and a decode helper for the
//            HI/LO multiply/divide engine.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } muldiv_op_t;

    // HI/LO-class codes are 0100xx (move) and 0110xx (multiply/divide).
    function automatic logic is_hilo_class(input logic [5:0] funct);
        return (funct[5:4] == 2'b01) && (funct[2] == 1'b0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module   : muldiv_step
// Brief    : One combinational iteration: shift-add multiply or restoring
//            divide on a {hi,lo} accumulator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 op_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        w_rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, operand};
        acc_next = '0;
        if (op_div) begin
            // The partial remainder stays below the divisor, so a clear top
            // bit of the difference means the trial subtraction succeeded.
            if (!w_diff[WIDTH]) begin
                acc_next = {w_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {w_rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_next = {w_sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative multiply/divide engine with architectural HI/LO.
//            Signed MULT/DIV enabled by defining MULDIV_SIGNED_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hilo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int              CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    muldiv_state_t       r_state;
    muldiv_state_t       w_state_next;
    muldiv_op_t          r_op;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*WIDTH-1:0]  r_acc;
    logic [2*WIDTH-1:0]  w_acc_next;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic                r_div0;
    logic                r_done;

    logic                w_class;
    logic                w_accept;
    logic                w_signed;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [WIDTH-1:0]    w_mag_a;
    logic [WIDTH-1:0]    w_mag_b;
    logic [2*WIDTH-1:0]  w_prod;
    logic [WIDTH-1:0]    w_quo;
    logic [WIDTH-1:0]    w_rem;

    assign w_class  = is_hilo_class(funct);
    assign busy     = (r_state != IDLE);
    assign stall    = start && busy && w_class;
    assign w_accept = start && w_class && !busy;
    assign hilo     = (funct == FUNCT_MFHI) ? r_hi : r_lo;
    assign done     = r_done;

`ifdef MULDIV_SIGNED_EN
    assign w_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
`else
    assign w_signed = 1'b0;
`endif

    assign w_neg_a = w_signed && src_a[WIDTH-1];
    assign w_neg_b = w_signed && src_b[WIDTH-1];
    assign w_mag_a = w_neg_a ? -src_a : src_a;
    assign w_mag_b = w_neg_b ? -src_b : src_b;

    muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .op_div   (r_op == OP_DIV),
        .acc      (r_acc),
        .operand  (r_b),
        .acc_next (w_acc_next)
    );

    // -2^(W-1) / -1 needs no special path: magnitudes give quotient
    // 2^(W-1), remainder 0, and the positive sign leaves that pattern intact.
    always_comb begin
        w_prod = r_neg_res ? -r_acc : r_acc;
        w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        if (r_div0) begin
            w_quo = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && funct[3]) w_state_next = RUN;
            RUN:     if (r_cnt == C_LAST)      w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= OP_MUL;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (funct == FUNCT_MTHI) r_hi <= src_a;
                        if (funct == FUNCT_MTLO) r_lo <= src_a;
                        if (funct[3]) begin
                            r_op      <= funct[1] ? OP_DIV : OP_MUL;
                            r_acc     <= {{WIDTH{1'b0}}, w_mag_a};
                            r_b       <= w_mag_b;
                            r_cnt     <= '0;
                            r_neg_res <= w_neg_a ^ w_neg_b;
                            r_neg_rem <= w_neg_a;
                            r_div0    <= (src_b == '0);
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    if (r_op == OP_DIV) begin
                        r_lo <= w_quo;
                        r_hi <= w_rem;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Sequential multiply/divide engine with architectural HI/LO registers for the pipelined MIPS core. Sits in the execute stage next to the ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from execute and computes products and quotients iteratively, one bit per cycle. It returns HI/LO to the writeback path and asserts `stall` to the hazard unit while a HI/LO-class instruction must wait.

## Interface
- `WIDTH`, 32, operand and HI/LO width; must be even, ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  valid instruction present in execute this cycle.
- `funct`  in  6  function code of that instruction.
- `src_a`  in  WIDTH  rs operand.
- `src_b`  in  WIDTH  rt operand.
- `hilo`  out  WIDTH  HI when `funct`=MFHI, else LO; combinational from registers.
- `busy`  out  1  engine not in IDLE.
- `stall`  out  1  `start` && `busy` && `funct` is HI/LO-class.
- `done`  out  1  one-cycle pulse after HI/LO written by a MULT/DIV.

## Operation
- Funct codes:
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - Anything else is ignored: no state change, `stall`=0.
- Accept condition: `start` && HI/LO-class && !`busy`. When `busy`, a HI/LO-class op raises `stall` and is not accepted; execute holds it until `stall` falls.
- MTHI/MTLO on accept: HI (or LO) ← `src_a` at that edge. No state change.
- MFHI/MFLO on accept: `hilo` is valid in the same cycle. No state change.
- MULT*/DIV* on accept:
  - Latch operand magnitudes (absolute values for signed ops), result signs and op type.
  - Clear the counter; state ← RUN.
- States:
  - IDLE → RUN on accept.
  - RUN iterates `WIDTH` cycles, then → FIX.
  - FIX applies sign correction, writes HI/LO, → IDLE.
- Multiply:
  - Shift-add, 2·WIDTH-bit accumulator.
  - {HI,LO} = full product.
  - Product sign = sign(a) ^ sign(b).
- Divide:
  - Restoring, one quotient bit per cycle.
  - LO = quotient, HI = remainder.
  - Quotient sign = sign(a) ^ sign(b); remainder sign = sign(a).
- Divide by zero (any signedness): LO = all ones, HI = `src_a`. No exception.
- Signed overflow (−2^(W−1) / −1): LO = 0x8000_0000, HI = 0.
- MT issued while not busy after a prior MULT overwrites that half only.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - HI = LO = 0.
  - `busy` = `stall` = `done` = 0.
- Accept edge E0. RUN iterations occur on edges E1..E32. FIX writes HI/LO at E33.
- `busy` is high in cycles E0+..E33−, i.e. 33 cycles for WIDTH=32. `done` is high in the cycle after E33.
- An MFHI/MFLO presented in the cycle after E33 reads the new value with no stall.
- A back-to-back MULT in the cycle after E33 is accepted immediately.
- `reset` mid-operation aborts the op: IDLE, HI/LO cleared, no `done`.
- `start` with a non-HI/LO funct while busy: `stall`=0, no effect.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - MULT/DIV are signed per above.
  - MULTU/DIVU are unsigned.
- Not defined:
  - MULT and DIV behave exactly as MULTU/DIVU.
  - Sign logic and overflow special case are removed.

## Structure
- `muldiv_pkg`:
  - funct localparams (`FUNCT_MFHI`…`FUNCT_DIVU`).
  - State enum `muldiv_state_t` {IDLE, RUN, FIX}.
  - Op enum `muldiv_op_t` {OP_MUL, OP_DIV}.
- Sub-module `muldiv_step`: combinational single iteration (shift-add or restore-subtract) on accumulator/remainder and operand. The top holds the FSM, counter and HI/LO.

## Test plan
- MULTU 0xFFFF_FFFF × 2 → at done HI=0x1, LO=0xFFFF_FFFE; `busy` 33 cycles.
- MULT −3 × 7 (signed build) → HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
- DIV −7 / 2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 7/0 → LO=0xFFFF_FFFF, HI=7.
- MFLO issued 1 cycle after MULT accept → `stall`=1 until done cycle, then `hilo` equals the new LO.
- MTHI 0x1234 then MFHI → `hilo`=0x1234, no stall. DIV 0x8000_0000 / −1 → LO=0x8000_0000, HI=0.
- `reset` asserted at RUN cycle 10 → next cycle `busy`=0, HI=LO=0, no `done` pulse.
